// File: rtl/agu_param_top.sv
// agu_param_top: parametrised NTT address generation unit.
// Each beat it emits conflict-free memory addresses and bank numbers for
// 2^LOG_LANES butterfly lanes, sweeping all stages forward or inverse, with a
// 2-stage ready/valid output pipeline.
// Optional feature macro: AGU_STALL_CNT_EN (backpressure cycle counter).
module agu_param_top #(
    parameter  int unsigned LOG_N     = 12,
    parameter  int unsigned LOG_LANES = 4,
    localparam int unsigned STAGES    = LOG_N / LOG_LANES,
    localparam int unsigned MA_W      = LOG_N - LOG_LANES,
    localparam int unsigned STG_W     = (STAGES > 1) ? $clog2(STAGES) : 1,
    localparam int unsigned LANES     = 1 << LOG_LANES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       inv_mode,
    output logic                       busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*MA_W-1:0]      ma_idx,
    output logic [LANES*LOG_LANES-1:0] bn_idx,
    output logic [STG_W-1:0]           out_stage,
    output logic                       out_last,
    output logic                       done,
    output logic [15:0]                stall_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [MA_W-1:0]   g_q, g_d;
    logic [STG_W-1:0]  s_q, s_d;
    logic              inv_q, inv_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // pipe stage 1: per-lane order words
    logic                   v1_q, last1_q;
    logic [STG_W-1:0]       stg1_q;
    logic [LANES*LOG_N-1:0] ord_q, ord_d;

    // pipe stage 2: translated outputs
    logic                       v2_q, last2_q;
    logic [STG_W-1:0]           stg2_q;
    logic [LANES*MA_W-1:0]      ma_q, ma_d;
    logic [LANES*LOG_LANES-1:0] bn_q, bn_d;

    logic adv2, adv1, issue, s_last, g_last, beat_last, fire_last;

    int unsigned       sr;
    logic [LOG_N-1:0]  gw, lo_mask;
    logic [LOG_LANES-1:0] bsum;

    // Handshake: stage 2 moves when empty or drained; stage 1 also refills when empty
    always_comb begin
        adv2      = !v2_q || out_ready;
        adv1      = adv2 || !v1_q;
        issue     = (state_q == RUN) && adv1;
        s_last    = inv_q ? (s_q == '0) : (s_q == STG_W'(STAGES - 1));
        g_last    = (g_q == '1);
        beat_last = s_last && g_last;
        fire_last = v2_q && out_ready && last2_q;
    end

    // Sweep FSM next-state: walks group index g within stage s
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        s_d     = s_q;
        inv_d   = inv_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    inv_d   = inv_mode;
                    g_d     = '0;
                    s_d     = inv_mode ? STG_W'(STAGES - 1) : '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (issue) begin
                    if (g_last) begin
                        g_d = '0;
                        if (s_last) state_d = DRAIN;
                        else        s_d = inv_q ? (s_q - STG_W'(1)) : (s_q + STG_W'(1));
                    end else begin
                        g_d = g_q + MA_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (fire_last) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and sweep registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= '0;
            s_q     <= '0;
            inv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            s_q     <= s_d;
            inv_q   <= inv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Order generation: insert lane digit at digit position s of g
    always_comb begin
        ord_d   = '0;
        sr      = int'(s_q) * LOG_LANES;
        gw      = LOG_N'(g_q);
        lo_mask = (LOG_N'(1) << sr) - LOG_N'(1);
        for (int i = 0; i < int'(LANES); i++) begin
            ord_d[i*LOG_N +: LOG_N] = ((gw >> sr) << (sr + LOG_LANES))
                                    | (LOG_N'(i) << sr)
                                    | (gw & lo_mask);
        end
    end

    // Translation: bank = digit sum mod L, address = order without lowest digit
    always_comb begin
        ma_d = '0;
        bn_d = '0;
        bsum = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            bsum = '0;
            for (int d = 0; d < int'(STAGES); d++) begin
                bsum = bsum + ord_q[i*LOG_N + d*LOG_LANES +: LOG_LANES];
            end
            bn_d[i*LOG_LANES +: LOG_LANES] = bsum;
            ma_d[i*MA_W +: MA_W]           = ord_q[i*LOG_N + LOG_LANES +: MA_W];
        end
    end

    // Two-stage output pipeline with bubble collapsing
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            stg1_q  <= '0;
            ord_q   <= '0;
            v2_q    <= 1'b0;
            last2_q <= 1'b0;
            stg2_q  <= '0;
            ma_q    <= '0;
            bn_q    <= '0;
        end else begin
            if (adv1) begin
                v1_q <= issue;
                if (issue) begin
                    ord_q   <= ord_d;
                    stg1_q  <= s_q;
                    last1_q <= beat_last;
                end
            end
            if (adv2) begin
                v2_q    <= v1_q;
                ma_q    <= ma_d;
                bn_q    <= bn_d;
                stg2_q  <= stg1_q;
                last2_q <= last1_q;
            end
        end
    end

`ifdef AGU_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Backpressure counter: cleared on accepted start, saturating
    always_comb begin
        stall_d = stall_q;
        if ((state_q == IDLE) && start)                         stall_d = '0;
        else if (v2_q && !out_ready && (stall_q != 16'hFFFF))   stall_d = stall_q + 16'd1;
    end

    // Backpressure counter register
    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = v2_q;
    assign ma_idx    = ma_q;
    assign bn_idx    = bn_q;
    assign out_stage = stg2_q;
    assign out_last  = last2_q;

endmodule

// File: tb/tb_agu_param_top.sv
// Self-checking bench for agu_param_top: hand-computed vector table plus
// directed sequences (sweeps, backpressure, reset, ignored start, small config).
module tb_agu_param_top;

    localparam int LN = 12, LR = 4, ST = 3, MW = 8, L = 16, G = 256, SW = 2;
    localparam int NB = ST * G;

    logic clk = 1'b0;
    logic rst, start, inv_mode, out_ready;
    logic busy, out_valid, out_last, done;
    logic [L*MW-1:0] ma_idx;
    logic [L*LR-1:0] bn_idx;
    logic [SW-1:0]   out_stage;
    logic [15:0]     stall_cnt;

    // small configuration: LOG_N=8 -> 2 stages of 16 groups
    logic            sm_start, sm_busy, sm_valid, sm_last, sm_done;
    logic [16*4-1:0] sm_ma, sm_bn;
    logic [0:0]      sm_stage;
    logic [15:0]     sm_stall;

    agu_param_top dut (
        .clk(clk), .rst(rst), .start(start), .inv_mode(inv_mode), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .ma_idx(ma_idx), .bn_idx(bn_idx),
        .out_stage(out_stage), .out_last(out_last), .done(done), .stall_cnt(stall_cnt)
    );

    agu_param_top #(.LOG_N(8), .LOG_LANES(4)) dut_sm (
        .clk(clk), .rst(rst), .start(sm_start), .inv_mode(1'b0), .busy(sm_busy),
        .out_valid(sm_valid), .out_ready(1'b1), .ma_idx(sm_ma), .bn_idx(sm_bn),
        .out_stage(sm_stage), .out_last(sm_last), .done(sm_done), .stall_cnt(sm_stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // reference: digits of g in order, lane digit placed at position s
    function automatic logic [LN-1:0] model_order(int s, int g, int lane);
        logic [LN-1:0] o = '0;
        int gd = 0;
        int dig;
        for (int d = 0; d < ST; d++) begin
            if (d == s) dig = lane;
            else begin
                dig = (g >> (4 * gd)) & 15;
                gd++;
            end
            o = o | (LN'(dig) << (4 * d));
        end
        return o;
    endfunction

    function automatic void model_beat(int s, int g, output logic [L*MW-1:0] ema,
                                       output logic [L*LR-1:0] ebn);
        logic [LN-1:0] o;
        int sum;
        ema = '0;
        ebn = '0;
        for (int i = 0; i < L; i++) begin
            o   = model_order(s, g, i);
            sum = int'(o[3:0]) + int'(o[7:4]) + int'(o[11:8]);
            ema[i*MW +: MW] = o[11:4];
            ebn[i*LR +: LR] = LR'(sum % 16);
        end
    endfunction

    // scoreboard state
    logic sb_inv;
    int   sb_s, sb_g, beats, last_cnt, last_beat, last_cyc, done_cnt, done_cyc;
    logic [L*MW-1:0] cap_ma [NB];
    logic [L*LR-1:0] cap_bn [NB];
    int              cap_stage [NB];
    logic            hold_pend = 1'b0;
    logic [L*MW-1:0] h_ma;
    logic [L*LR-1:0] h_bn;
    logic [SW-1:0]   h_stage;
    logic            h_last;

    task automatic sb_begin(input logic inv);
        sb_inv = inv; sb_s = inv ? ST - 1 : 0; sb_g = 0;
        beats = 0; last_cnt = 0; last_beat = -1; done_cnt = 0;
    endtask

    // monitor: stall hold, accepted-beat scoreboard, done pulses
    always @(negedge clk) begin
        logic [L*MW-1:0] ema;
        logic [L*LR-1:0] ebn;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (hold_pend) begin
            chk("hold_valid", 256'(out_valid), 256'(1));
            chk("hold_ma", 256'(ma_idx), 256'(h_ma));
            chk("hold_bn", 256'(bn_idx), 256'(h_bn));
            chk("hold_stage_last", 256'({out_stage, out_last}), 256'({h_stage, h_last}));
        end
        hold_pend = out_valid && !out_ready;
        if (hold_pend) begin h_ma = ma_idx; h_bn = bn_idx; h_stage = out_stage; h_last = out_last; end
        if (out_valid && out_ready) begin
            model_beat(sb_s, sb_g, ema, ebn);
            chk($sformatf("beat%0d_ma", beats), 256'(ma_idx), 256'(ema));
            chk($sformatf("beat%0d_bn", beats), 256'(bn_idx), 256'(ebn));
            chk($sformatf("beat%0d_stage", beats), 256'(out_stage), 256'(sb_s));
            chk($sformatf("beat%0d_last", beats), 256'(out_last), 256'(beats == NB - 1));
            if (beats < NB) begin
                cap_ma[beats] = ma_idx; cap_bn[beats] = bn_idx; cap_stage[beats] = int'(out_stage);
            end
            if (out_last) begin last_cnt++; last_beat = beats; last_cyc = cyc; end
            beats++;
            sb_g++;
            if (sb_g == G) begin sb_g = 0; sb_s = sb_inv ? sb_s - 1 : sb_s + 1; end
        end
    end

    int sm_beats = 0, sm_last_cnt = 0, sm_last_beat = -1;
    always @(negedge clk) begin
        if (sm_valid) begin
            if (sm_last) begin sm_last_cnt++; sm_last_beat = sm_beats; end
            sm_beats++;
        end
    end

    typedef struct {
        logic inv;
        int   s, g, lane, ma, bn;
    } vec_t;
    vec_t tbl [13];

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic pulse_start(input logic inv);
        start = 1'b1; inv_mode = inv; tick(); start = 1'b0; inv_mode = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int k = 0;
        while (beats < n && k < 5000) begin @(negedge clk); k++; end
        if (beats < n) chk("wait_beats_timeout", 256'(beats), 256'(n));
    endtask

    task automatic wait_done();
        int k = 0;
        @(negedge clk);
        while (!done && k < 3000) begin @(negedge clk); k++; end
        chk("done_seen", 256'(done), 256'(1));
        chk("busy_at_done", 256'(busy), 256'(0));
    endtask

    task automatic run_table(input logic inv);
        int idx;
        for (int k = 0; k < 13; k++) begin
            if (tbl[k].inv == inv) begin
                idx = inv ? (ST - 1 - tbl[k].s) * G + tbl[k].g : tbl[k].s * G + tbl[k].g;
                chk($sformatf("tbl%0d_ma", k), 256'(cap_ma[idx][tbl[k].lane*MW +: MW]), 256'(tbl[k].ma));
                chk($sformatf("tbl%0d_bn", k), 256'(cap_bn[idx][tbl[k].lane*LR +: LR]), 256'(tbl[k].bn));
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 256'(busy), 256'(0));
        chk({tag, "_valid"}, 256'(out_valid), 256'(0));
        chk({tag, "_ma"}, 256'(ma_idx), 256'(0));
        chk({tag, "_bn"}, 256'(bn_idx), 256'(0));
        chk({tag, "_stage"}, 256'(out_stage), 256'(0));
        chk({tag, "_last_done"}, 256'({out_last, done}), 256'(0));
        chk({tag, "_stall"}, 256'(stall_cnt), 256'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // {inv, s, g, lane, MA, BN}
        tbl[0]  = '{1'b0, 0, 8'h00,  0, 8'h00,  0};
        tbl[1]  = '{1'b0, 0, 8'h00,  9, 8'h00,  9};
        tbl[2]  = '{1'b0, 1, 8'h05,  3, 8'h03,  8};
        tbl[3]  = '{1'b0, 1, 8'h05, 15, 8'h0F,  4};
        tbl[4]  = '{1'b0, 2, 8'h13,  2, 8'h21,  6};
        tbl[5]  = '{1'b0, 2, 8'h13, 15, 8'hF1,  3};
        tbl[6]  = '{1'b0, 0, 8'h12,  7, 8'h12, 10};
        tbl[7]  = '{1'b0, 0, 8'hFF, 15, 8'hFF, 13};
        tbl[8]  = '{1'b0, 1, 8'hAB,  9, 8'hA9, 14};
        tbl[9]  = '{1'b1, 2, 8'h00,  5, 8'h50,  5};
        tbl[10] = '{1'b1, 2, 8'h00,  0, 8'h00,  0};
        tbl[11] = '{1'b1, 0, 8'h00, 12, 8'h00, 12};
        tbl[12] = '{1'b1, 1, 8'h05,  3, 8'h03,  8};

        rst = 1'b1; start = 1'b0; inv_mode = 1'b0; out_ready = 1'b1; sm_start = 1'b0;
        sb_begin(1'b0);
        repeat (2) tick();
        @(negedge clk);
        chk_all_zero("reset");
        tick();
        rst = 1'b0;
        tick();

        // forward sweep with an ignored start (inv_mode=1) mid-sweep
        sb_begin(1'b0);
        pulse_start(1'b0);
        @(negedge clk);
        chk("busy_rise", 256'({busy, out_valid}), 256'(2'b10));
        @(negedge clk);
        chk("valid_lat1", 256'(out_valid), 256'(0));
        @(negedge clk);
        chk("valid_lat2", 256'(out_valid), 256'(1));
        wait_beats(50);
        tick();
        pulse_start(1'b1);
        wait_done();
        @(negedge clk);
        chk("fwd_beats", 256'(beats), 256'(NB));
        chk("fwd_last_cnt", 256'(last_cnt), 256'(1));
        chk("fwd_last_beat", 256'(last_beat), 256'(NB - 1));
        chk("fwd_done_lat", 256'(done_cyc), 256'(last_cyc + 1));
        chk("fwd_done_pulse", 256'({done, done_cnt}), 256'({1'b0, 32'd1}));
        run_table(1'b0);

        // inverse sweep
        tick();
        sb_begin(1'b1);
        pulse_start(1'b1);
        wait_done();
        @(negedge clk);
        chk("inv_beats", 256'(beats), 256'(NB));
        chk("inv_stage_0", 256'(cap_stage[0]), 256'(2));
        chk("inv_stage_255", 256'(cap_stage[255]), 256'(2));
        chk("inv_stage_256", 256'(cap_stage[256]), 256'(1));
        chk("inv_stage_511", 256'(cap_stage[511]), 256'(1));
        chk("inv_stage_512", 256'(cap_stage[512]), 256'(0));
        chk("inv_stage_767", 256'(cap_stage[767]), 256'(0));
        run_table(1'b1);

        // backpressure: 5 cycles of out_ready low mid-stage
        tick();
        sb_begin(1'b0);
        pulse_start(1'b0);
        wait_beats(300);
        tick();
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
        wait_done();
        @(negedge clk);
        chk("bp_beats", 256'(beats), 256'(NB));
        chk("bp_last_cnt", 256'(last_cnt), 256'(1));
`ifdef AGU_STALL_CNT_EN
        chk("bp_stall_cnt", 256'(stall_cnt), 256'(5));
        repeat (3) tick();
        chk("bp_stall_hold", 256'(stall_cnt), 256'(5));
`else
        chk("bp_stall_cnt", 256'(stall_cnt), 256'(0));
`endif

        // reset at beat 100, then a fresh sweep
        tick();
        sb_begin(1'b0);
        pulse_start(1'b0);
        wait_beats(100);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("midrst");
        repeat (30) tick();
        chk("midrst_no_done", 256'(done_cnt), 256'(0));
        chk("midrst_idle", 256'({busy, out_valid}), 256'(0));
        sb_begin(1'b0);
        pulse_start(1'b0);
        wait_beats(1);
        chk("rst_new_stage", 256'(cap_stage[0]), 256'(0));
        chk("rst_new_ma", 256'(cap_ma[0]), 256'(0));
        chk("rst_new_bn", 256'(cap_bn[0]), 256'(64'hFEDC_BA98_7654_3210));
        wait_done();
        @(negedge clk);
        chk("rst_new_beats", 256'(beats), 256'(NB));

        // LOG_N=8: 2 stages x 16 groups = 32 beats, ignored restart mid-sweep
        tick();
        sm_start = 1'b1; tick(); sm_start = 1'b0;
        repeat (10) tick();
        sm_start = 1'b1; tick(); sm_start = 1'b0;
        begin
            int k = 0;
            @(negedge clk);
            while (!sm_done && k < 500) begin @(negedge clk); k++; end
        end
        chk("sm_done_seen", 256'(sm_done), 256'(1));
        chk("sm_beats", 256'(sm_beats), 256'(32));
        chk("sm_last", 256'({sm_last_cnt, sm_last_beat}), 256'({32'd1, 32'd31}));
        chk("sm_busy_low", 256'(sm_busy), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
